palette_loader: RTL and testbench

- Avalon-MM master that fills the 8x4 color palette register file. It copies a run of 24-bit RGB entries from a source memory into consecutive palette slots.
- Sits between the HPS/SDRAM-side fabric (source read port) and the color palette slave (palette port). Software starts a bulk palette swap with one start pulse instead of issuing 32 individual writes.
- Runs on the 100 MHz palette-side clock.

---
 rtl/palette_pkg.sv | 20 ++
 rtl/palette_loader.sv | 164 ++++++++++++++++
 tb/tb_palette_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared palette constants, RGB type and loader state encoding
package palette_pkg;

   localparam int PAL_IDX_W = 5;
   localparam int RGB_W = 24;
   localparam logic [3:0] PAL_BE = 4'b0111;

   typedef logic [RGB_W-1:0] rgb_t;

   typedef enum logic [2:0] {
      LDR_IDLE        = 3'd0,
      LDR_SRC_REQ     = 3'd1,
      LDR_SRC_WAIT    = 3'd2,
      LDR_PAL_WR      = 3'd3,
      LDR_PAL_RB_REQ  = 3'd4,
      LDR_PAL_RB_WAIT = 3'd5,
      LDR_FIN         = 3'd6
   } ldr_state_t;

endpackage

// File: rtl/palette_loader.sv
// rtl/palette_loader.sv - bulk copy of RGB entries from source memory into palette slots
// Optional readback verification of each written slot: PALETTE_LOADER_READBACK_EN
module palette_loader
   import palette_pkg::*;
#(
   parameter int SRC_ADDR_W     = 32,
   parameter int MAX_ENTRIES    = 32,
   parameter int PAL_RD_LATENCY = 1
) (
   input  logic                  CLK_100,
   input  logic                  RESET_N,
   input  logic                  START,
   input  logic [SRC_ADDR_W-1:0] SRC_BASE,
   input  logic [5:0]            COUNT,
   input  logic [PAL_IDX_W-1:0]  DST_INDEX,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR,
   output logic [SRC_ADDR_W-1:0] SRC_ADDR,
   output logic                  SRC_READ,
   input  logic                  SRC_WAITREQUEST,
   input  logic                  SRC_READDATAVALID,
   input  logic [31:0]           SRC_READDATA,
   output logic [PAL_IDX_W-1:0]  PAL_ADDR,
   output logic [31:0]           PAL_WRITEDATA,
   output logic [3:0]            PAL_BYTE_EN,
   output logic                  PAL_WRITE,
   output logic                  PAL_READ,
   output logic                  PAL_CS,
   input  logic                  PAL_WAITREQUEST,
   input  logic [31:0]           PAL_READDATA
);

   ldr_state_t            state_q, state_d;
   logic [SRC_ADDR_W-1:0] addr_q, addr_d;
   logic [PAL_IDX_W-1:0]  slot_q, slot_d;
   logic [5:0]            remain_q, remain_d;
   rgb_t                  rgb_q, rgb_d;
   logic [5:0]            count_clamped;

   assign count_clamped = (COUNT > 6'(MAX_ENTRIES)) ? 6'(MAX_ENTRIES) : COUNT;

`ifdef PALETTE_LOADER_READBACK_EN
   localparam int LAT_W = 8;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             error_q, error_d;
   logic             unused_bits;
   assign unused_bits = ^{SRC_BASE[1:0], SRC_READDATA[31:24], PAL_READDATA[31:24]};
`else
   localparam int UNUSED_LAT = PAL_RD_LATENCY;
   logic unused_bits;
   assign unused_bits = ^{SRC_BASE[1:0], SRC_READDATA[31:24], PAL_READDATA};
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      slot_d   = slot_q;
      remain_d = remain_q;
      rgb_d    = rgb_q;
`ifdef PALETTE_LOADER_READBACK_EN
      lat_d    = lat_q;
      error_d  = error_q;
`endif
      case (state_q)
         LDR_IDLE: begin
            if (START) begin
               addr_d   = {SRC_BASE[SRC_ADDR_W-1:2], 2'b00};
               slot_d   = DST_INDEX;
               remain_d = count_clamped;
`ifdef PALETTE_LOADER_READBACK_EN
               error_d  = 1'b0;
`endif
               state_d  = (count_clamped == 6'd0) ? LDR_FIN : LDR_SRC_REQ;
            end
         end
         LDR_SRC_REQ: begin
            if (!SRC_WAITREQUEST) state_d = LDR_SRC_WAIT;
         end
         LDR_SRC_WAIT: begin
            if (SRC_READDATAVALID) begin
               rgb_d   = SRC_READDATA[RGB_W-1:0];
               state_d = LDR_PAL_WR;
            end
         end
         LDR_PAL_WR: begin
            if (!PAL_WAITREQUEST) begin
               slot_d   = slot_q + 5'd1;
               addr_d   = addr_q + SRC_ADDR_W'(4);
               remain_d = remain_q - 6'd1;
`ifdef PALETTE_LOADER_READBACK_EN
               state_d  = LDR_PAL_RB_REQ;
`else
               state_d  = (remain_q == 6'd1) ? LDR_FIN : LDR_SRC_REQ;
`endif
            end
         end
`ifdef PALETTE_LOADER_READBACK_EN
         LDR_PAL_RB_REQ: begin
            if (!PAL_WAITREQUEST) begin
               lat_d   = LAT_W'(PAL_RD_LATENCY - 1);
               state_d = LDR_PAL_RB_WAIT;
            end
         end
         LDR_PAL_RB_WAIT: begin
            // Readback data is valid on the last latency cycle only.
            if (lat_q == '0) begin
               if (PAL_READDATA[RGB_W-1:0] != rgb_q) error_d = 1'b1;
               state_d = (remain_q == 6'd0) ? LDR_FIN : LDR_SRC_REQ;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
`endif
         LDR_FIN: state_d = LDR_IDLE;
         default: state_d = LDR_IDLE;
      endcase
   end

   always_ff @(posedge CLK_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= LDR_IDLE;
         addr_q   <= '0;
         slot_q   <= '0;
         remain_q <= '0;
         rgb_q    <= '0;
`ifdef PALETTE_LOADER_READBACK_EN
         lat_q    <= '0;
         error_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         slot_q   <= slot_d;
         remain_q <= remain_d;
         rgb_q    <= rgb_d;
`ifdef PALETTE_LOADER_READBACK_EN
         lat_q    <= lat_d;
         error_q  <= error_d;
`endif
      end
   end

   // Bus outputs are decoded from state so they idle at zero outside their phase.
   assign BUSY      = (state_q != LDR_IDLE) && (state_q != LDR_FIN);
   assign DONE      = (state_q == LDR_FIN);
   assign SRC_READ  = (state_q == LDR_SRC_REQ);
   assign SRC_ADDR  = SRC_READ ? addr_q : '0;
   assign PAL_WRITE = (state_q == LDR_PAL_WR);

`ifdef PALETTE_LOADER_READBACK_EN
   assign PAL_READ  = (state_q == LDR_PAL_RB_REQ);
   assign ERROR     = error_q;
`else
   assign PAL_READ  = 1'b0;
   assign ERROR     = 1'b0;
`endif

   assign PAL_CS        = PAL_WRITE | PAL_READ;
   assign PAL_ADDR      = PAL_WRITE ? slot_q : (PAL_READ ? slot_q - 5'd1 : '0);
   assign PAL_WRITEDATA = PAL_WRITE ? {8'h00, rgb_q} : 32'h0;
   assign PAL_BYTE_EN   = PAL_CS ? PAL_BE : 4'b0000;

endmodule

// File: tb/tb_palette_loader.sv
// tb/tb_palette_loader.sv - scoreboard bench for palette_loader with randomized runs
module tb_palette_loader;

   logic        CLK_100 = 1'b0;
   logic        RESET_N = 1'b0;
   logic        START = 1'b0;
   logic [31:0] SRC_BASE = 32'h0;
   logic [5:0]  COUNT = 6'd0;
   logic [4:0]  DST_INDEX = 5'd0;
   logic        BUSY, DONE, ERROR;
   logic [31:0] SRC_ADDR;
   logic        SRC_READ;
   logic        SRC_WAITREQUEST = 1'b0;
   logic        SRC_READDATAVALID = 1'b0;
   logic [31:0] SRC_READDATA = 32'h0;
   logic [4:0]  PAL_ADDR;
   logic [31:0] PAL_WRITEDATA;
   logic [3:0]  PAL_BYTE_EN;
   logic        PAL_WRITE, PAL_READ, PAL_CS;
   logic        PAL_WAITREQUEST = 1'b0;
   logic [31:0] PAL_READDATA = 32'h0;

   palette_loader dut (
      .CLK_100(CLK_100), .RESET_N(RESET_N), .START(START), .SRC_BASE(SRC_BASE),
      .COUNT(COUNT), .DST_INDEX(DST_INDEX), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
      .SRC_ADDR(SRC_ADDR), .SRC_READ(SRC_READ), .SRC_WAITREQUEST(SRC_WAITREQUEST),
      .SRC_READDATAVALID(SRC_READDATAVALID), .SRC_READDATA(SRC_READDATA),
      .PAL_ADDR(PAL_ADDR), .PAL_WRITEDATA(PAL_WRITEDATA), .PAL_BYTE_EN(PAL_BYTE_EN),
      .PAL_WRITE(PAL_WRITE), .PAL_READ(PAL_READ), .PAL_CS(PAL_CS),
      .PAL_WAITREQUEST(PAL_WAITREQUEST), .PAL_READDATA(PAL_READDATA)
   );

   always #5 CLK_100 = ~CLK_100;

`ifdef PALETTE_LOADER_READBACK_EN
   localparam int PER_ENTRY = 5;
`else
   localparam int PER_ENTRY = 3;
`endif

   int total = 0;
   int bad = 0;

   logic [31:0] exp_src_q[$];
   logic [36:0] exp_wr_q[$];
   int          src_stall = 0;
   int          pal_stall = 0;
   logic [31:0] base_g = 32'h0;
   logic [23:0] xor_g = 24'h0;
   int          corrupt_idx = -1;
   int          rb_idx = 0;
   int          wr_cnt = 0;
   int          src_rd_cycles = 0;
   logic [31:0] last_src_addr = 32'h0;
   logic [23:0] pal_mem [32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Source memory: word at byte offset 4n from the run base holds {FF, n ^ xor_g}.
   initial begin
      int          wcnt = 0;
      bit          acc = 0;
      logic [31:0] aa = 32'h0;
      logic [23:0] n24;
      forever begin
         @(negedge CLK_100);
         SRC_READDATAVALID = 1'b0;
         SRC_READDATA = $urandom;
         if (!RESET_N) begin
            wcnt = 0; acc = 0; SRC_WAITREQUEST = 1'b0;
         end else begin
            if (acc) begin
               n24 = 24'((aa - base_g) >> 2);
               SRC_READDATAVALID = 1'b1;
               SRC_READDATA = {8'hFF, n24 ^ xor_g};
               acc = 0;
            end
            if (SRC_READ) begin
               if (wcnt < src_stall) begin
                  SRC_WAITREQUEST = 1'b1; wcnt++;
               end else begin
                  SRC_WAITREQUEST = 1'b0; wcnt = 0; acc = 1; aa = SRC_ADDR;
               end
            end else begin
               SRC_WAITREQUEST = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Palette slave with storage and a one-cycle read latency.
   initial begin
      int         wcnt = 0;
      bit         rd_pend = 0;
      logic [4:0] ra = 5'd0;
      forever begin
         @(negedge CLK_100);
         PAL_READDATA = $urandom;
         if (!RESET_N) begin
            wcnt = 0; rd_pend = 0; PAL_WAITREQUEST = 1'b0;
         end else begin
            if (rd_pend) begin
               PAL_READDATA = {8'h00, pal_mem[ra]} ^ ((rb_idx == corrupt_idx) ? 32'h20 : 32'h0);
               rb_idx++;
               rd_pend = 0;
            end
            if (PAL_WRITE) begin
               if (wcnt < pal_stall) begin
                  PAL_WAITREQUEST = 1'b1; wcnt++;
               end else begin
                  PAL_WAITREQUEST = 1'b0; wcnt = 0;
                  pal_mem[PAL_ADDR] = PAL_WRITEDATA[23:0];
               end
            end else if (PAL_READ) begin
               PAL_WAITREQUEST = 1'b0; rd_pend = 1; ra = PAL_ADDR;
            end else begin
               PAL_WAITREQUEST = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Monitor: pops expectations on each accepted transfer and checks stall stability.
   initial begin
      bit          ss = 0;
      bit          ps = 0;
      logic [31:0] sa = 32'h0;
      logic [36:0] pw = 37'h0;
      forever begin
         @(negedge CLK_100);
         #1;
         if (SRC_READ) begin
            src_rd_cycles++;
            if (ss) check("src_addr_stable", 64'(SRC_ADDR), 64'(sa));
            if (!SRC_WAITREQUEST) begin
               ss = 0;
               last_src_addr = SRC_ADDR;
               if (exp_src_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL src_unexpected actual=0x%0h required=none", SRC_ADDR);
               end else begin
                  check("src_addr", 64'(SRC_ADDR), 64'(exp_src_q.pop_front()));
               end
            end else begin
               ss = 1; sa = SRC_ADDR;
            end
         end else begin
            ss = 0;
         end
         if (PAL_WRITE) begin
            if (ps) check("pal_stable", 64'({PAL_ADDR, PAL_WRITEDATA}), 64'(pw));
            check("pal_cs_be", 64'({PAL_CS, PAL_BYTE_EN}), 64'(5'b10111));
            if (!PAL_WAITREQUEST) begin
               ps = 0;
               wr_cnt++;
               if (exp_wr_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL pal_unexpected actual=0x%0h required=none", {PAL_ADDR, PAL_WRITEDATA});
               end else begin
                  check("pal_write", 64'({PAL_ADDR, PAL_WRITEDATA}), 64'(exp_wr_q.pop_front()));
               end
            end else begin
               ps = 1; pw = {PAL_ADDR, PAL_WRITEDATA};
            end
         end else begin
            ps = 0;
         end
      end
   end

   task automatic push_model(input logic [31:0] base, input int cnt, input logic [4:0] dst);
      int          n;
      logic [31:0] ab;
      n = (cnt > 32) ? 32 : cnt;
      ab = base & ~32'h3;
      base_g = ab;
      for (int i = 0; i < n; i++) begin
         exp_src_q.push_back(ab + 32'(4 * i));
         exp_wr_q.push_back({5'((int'(dst) + i) % 32), 8'h00, 24'(i) ^ xor_g});
      end
   endtask

   task automatic run(input logic [31:0] base, input int cnt, input logic [4:0] dst,
                      input bit exp_err, output int cyc, output int busy_cyc);
      int n;
      n = (cnt > 32) ? 32 : cnt;
      push_model(base, cnt, dst);
      rb_idx = 0; wr_cnt = 0; src_rd_cycles = 0;
      @(negedge CLK_100);
      SRC_BASE = base; COUNT = 6'(cnt); DST_INDEX = dst; START = 1'b1;
      @(negedge CLK_100);
      START = 1'b0;
      cyc = 1; busy_cyc = 0;
      check("error_cleared", 64'(ERROR), 64'(0));
      while (!DONE && cyc < 3000) begin
         if (BUSY) busy_cyc++;
         START = (cyc == 2);
         if (cyc == 2) SRC_BASE = ~base;
         @(negedge CLK_100);
         cyc++;
      end
      check("done_seen", 64'(DONE), 64'(1));
      check("busy_at_done", 64'(BUSY), 64'(0));
      check("error_at_done", 64'(ERROR), 64'(exp_err));
      START = 1'b1;
      @(negedge CLK_100);
      START = 1'b0;
      check("idle_after_done", 64'({BUSY, DONE}), 64'(0));
      #2;
      check("wr_queue_empty", 64'(exp_wr_q.size()), 64'(0));
      check("src_queue_empty", 64'(exp_src_q.size()), 64'(0));
      check("write_count", 64'(wr_cnt), 64'(n));
   endtask

   task automatic check_all_zero(input string name);
      check(name, 64'({BUSY, DONE, ERROR, SRC_READ, PAL_WRITE, PAL_READ, PAL_CS, PAL_BYTE_EN})
                  | 64'(SRC_ADDR) | 64'(PAL_ADDR) | 64'(PAL_WRITEDATA), 64'(0));
   endtask

   initial begin
      int cyc, busy;
      int cnt;
      bit hit;
      logic [31:0] base;
      repeat (3) @(negedge CLK_100);
      check_all_zero("reset_outputs");
      RESET_N = 1'b1;

      // Zero-wait copy and latency.
      run(32'h1000, 4, 5'd8, 1'b0, cyc, busy);
      check("t1_done_cycle", 64'(cyc), 64'(1 + 4 * PER_ENTRY));
      check("t1_busy_cycles", 64'(busy), 64'(4 * PER_ENTRY));

      // Stalls on both ports.
      src_stall = 3; pal_stall = 2; xor_g = 24'($urandom);
      run(32'h2006, 3, 5'd5, 1'b0, cyc, busy);
      src_stall = 0; pal_stall = 0;

      // Slot wrap and count clamp.
      xor_g = 24'($urandom);
      run(32'h4000, 40, 5'd30, 1'b0, cyc, busy);
      check("t3_last_src_addr", 64'(last_src_addr), 64'(32'h4000 + 32'h7C));

      // Empty run.
      run(32'h5000, 0, 5'd3, 1'b0, cyc, busy);
      check("t4_done_cycle", 64'(cyc), 64'(1));
      check("t4_no_src_read", 64'(src_rd_cycles), 64'(0));

      // Asynchronous reset during the second palette write.
      xor_g = 24'h0;
      push_model(32'h6000, 4, 5'd0);
      wr_cnt = 0;
      @(negedge CLK_100);
      SRC_BASE = 32'h6000; COUNT = 6'd4; DST_INDEX = 5'd0; START = 1'b1;
      @(negedge CLK_100);
      START = 1'b0;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (PAL_WRITE && wr_cnt == 1) hit = 1;
         else @(negedge CLK_100);
      end
      check("t5_second_write_seen", 64'(hit), 64'(1));
      RESET_N = 1'b0;
      #1;
      check_all_zero("t5_reset_outputs");
      exp_src_q.delete(); exp_wr_q.delete();
      repeat (2) @(negedge CLK_100);
      check_all_zero("t5_reset_held");
      RESET_N = 1'b1;
      @(negedge CLK_100);
      check("t5_idle_after_reset", 64'({BUSY, DONE, SRC_READ, PAL_WRITE}), 64'(0));
      run(32'h7000, 5, 5'd12, 1'b0, cyc, busy);

`ifdef PALETTE_LOADER_READBACK_EN
      corrupt_idx = 1;
      run(32'h8000, 4, 5'd20, 1'b1, cyc, busy);
      corrupt_idx = -1;
      run(32'h8100, 2, 5'd4, 1'b0, cyc, busy);
`endif

      // Randomized runs.
      for (int k = 0; k < 8; k++) begin
         src_stall = $urandom_range(0, 2);
         pal_stall = $urandom_range(0, 2);
         xor_g = 24'($urandom);
         base = $urandom;
         cnt = $urandom_range(0, 40);
         run(base, cnt, 5'($urandom), 1'b0, cyc, busy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
